// File: rtl/neuroset_pkg.sv
// Shared types and constants for the neuroset result stage.
// Optional margin output is enabled by DENSE_ARGMAX_MARGIN_EN.
package neuroset_pkg;

    localparam int ARGMAX_SIZE_1 = 11;
    localparam int ARGMAX_ADDR_W = 13;
    localparam int CLS_W = 4;

    localparam logic signed [ARGMAX_SIZE_1-1:0] ARGMAX_MIN =
        {1'b1, {(ARGMAX_SIZE_1-1){1'b0}}};

    typedef enum logic [1:0] {
        ARGMAX_IDLE,
        ARGMAX_READ,
        ARGMAX_DRAIN,
        ARGMAX_DONE
    } argmax_state_e;

endpackage

// File: rtl/argmax_cmp.sv
// Registered compare-and-update cell for a running signed maximum.
// With DENSE_ARGMAX_MARGIN_EN it also tracks the runner-up and margin.
module argmax_cmp
    import neuroset_pkg::*;
#(
    parameter int W  = ARGMAX_SIZE_1,
    parameter int IW = CLS_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                in_vld,
    input  logic                first,
    input  logic signed [W-1:0] in_val,
    input  logic [IW-1:0]       in_idx,
`ifdef DENSE_ARGMAX_MARGIN_EN
    input  logic                sat_set,
    output logic signed [W:0]   margin_q,
`endif
    output logic signed [W-1:0] max_q,
    output logic [IW-1:0]       idx_q
);

    localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    logic take;

    assign take = in_vld && (first || (in_val > max_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= MIN_V;
            idx_q <= '0;
        end else if (clr) begin
            max_q <= MIN_V;
            idx_q <= '0;
        end else if (take) begin
            max_q <= in_val;
            idx_q <= in_idx;
        end
    end

`ifdef DENSE_ARGMAX_MARGIN_EN
    localparam logic signed [W:0] SAT_V = {1'b0, {W{1'b1}}};

    logic signed [W-1:0] sec_q, sec_n, max_n;
    logic                sv_q, sv_n;
    logic signed [W:0]   margin_n;

    always_comb begin
        sec_n = sec_q;
        sv_n  = sv_q;
        max_n = take ? in_val : max_q;
        if (in_vld) begin
            if (first) begin
                sec_n = MIN_V;
                sv_n  = 1'b0;
            end else if (in_val > max_q) begin
                sec_n = max_q;
                sv_n  = 1'b1;
            end else if (in_val == max_q || !sv_q || in_val > sec_q) begin
                // ties with the max collapse the margin to zero
                sec_n = in_val;
                sv_n  = 1'b1;
            end
        end
        margin_n = margin_q;
        if (sat_set) begin
            margin_n = SAT_V;
        end else if (in_vld) begin
            margin_n = sv_n ? ({max_n[W-1], max_n} - {sec_n[W-1], sec_n})
                            : SAT_V;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q    <= MIN_V;
            sv_q     <= 1'b0;
            margin_q <= '0;
        end else if (clr) begin
            sec_q    <= MIN_V;
            sv_q     <= 1'b0;
            margin_q <= '0;
        end else begin
            sec_q    <= sec_n;
            sv_q     <= sv_n;
            margin_q <= margin_n;
        end
    end
`endif

endmodule

// File: rtl/dense_argmax.sv
// Scans dense-layer outputs from pixel memory and reports the argmax.
// Define DENSE_ARGMAX_MARGIN_EN to add the margin_o output.
module dense_argmax
    import neuroset_pkg::*;
#(
    parameter int SIZE_1           = ARGMAX_SIZE_1,
    parameter int SIZE_address_pix = ARGMAX_ADDR_W,
    parameter int READ_LAT         = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          result_en,
    input  logic [3:0]                    out,
    input  logic [SIZE_address_pix-1:0]   memstartp,
    input  logic signed [SIZE_1-1:0]      qp,
    output logic                          re_p,
    output logic [SIZE_address_pix-1:0]   read_addressp,
    output logic [3:0]                    class_o,
    output logic signed [SIZE_1-1:0]      max_o,
`ifdef DENSE_ARGMAX_MARGIN_EN
    output logic signed [SIZE_1:0]        margin_o,
`endif
    output logic                          STOP
);

    argmax_state_e state_q, state_n;

    logic [CLS_W-1:0]            issue_q, issue_n;
    logic [CLS_W-1:0]            smp_q, smp_n;
    logic [READ_LAT:0]           vld_q, vld_n;
    logic                        re_n, stop_n, issue, take, last;
    logic [SIZE_address_pix-1:0] addr_n;

    assign take = vld_q[READ_LAT];
    assign last = take && (smp_q == out - 4'd1);

    always_comb begin
        state_n = state_q;
        issue_n = issue_q;
        smp_n   = smp_q;
        re_n    = re_p;
        addr_n  = read_addressp;
        stop_n  = STOP;
        issue   = 1'b0;
        unique case (state_q)
            ARGMAX_IDLE: begin
                if (out == 4'd0) begin
                    state_n = ARGMAX_DONE;
                    stop_n  = 1'b1;
                end else begin
                    state_n = ARGMAX_READ;
                    re_n    = 1'b1;
                    addr_n  = memstartp;
                    issue_n = 4'd1;
                    issue   = 1'b1;
                end
            end
            ARGMAX_READ: begin
                if (issue_q == out) begin
                    re_n    = 1'b0;
                    state_n = ARGMAX_DRAIN;
                end else begin
                    addr_n  = memstartp + SIZE_address_pix'(issue_q);
                    issue_n = issue_q + 4'd1;
                    issue   = 1'b1;
                end
            end
            ARGMAX_DRAIN: ;
            ARGMAX_DONE: ;
            default: state_n = ARGMAX_IDLE;
        endcase
        if (take) smp_n = smp_q + 4'd1;
        if (last) begin
            state_n = ARGMAX_DONE;
            stop_n  = 1'b1;
        end
        // dropping the enable discards everything, including reads in flight
        if (!result_en) begin
            state_n = ARGMAX_IDLE;
            re_n    = 1'b0;
            addr_n  = '0;
            stop_n  = 1'b0;
            issue_n = '0;
            smp_n   = '0;
            issue   = 1'b0;
        end
        vld_n = result_en ? ((vld_q << 1) | (READ_LAT+1)'(issue)) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARGMAX_IDLE;
            issue_q       <= '0;
            smp_q         <= '0;
            vld_q         <= '0;
            re_p          <= 1'b0;
            read_addressp <= '0;
            STOP          <= 1'b0;
        end else begin
            state_q       <= state_n;
            issue_q       <= issue_n;
            smp_q         <= smp_n;
            vld_q         <= vld_n;
            re_p          <= re_n;
            read_addressp <= addr_n;
            STOP          <= stop_n;
        end
    end

    argmax_cmp #(
        .W  (SIZE_1),
        .IW (CLS_W)
    ) u_cmp (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (!result_en),
        .in_vld   (take),
        .first    (smp_q == 4'd0),
        .in_val   (qp),
        .in_idx   (smp_q),
`ifdef DENSE_ARGMAX_MARGIN_EN
        .sat_set  (state_q == ARGMAX_IDLE && result_en && out == 4'd0),
        .margin_q (margin_o),
`endif
        .max_q    (max_o),
        .idx_q    (class_o)
    );

endmodule

// File: tb/tb_dense_argmax.sv
// Directed self-checking bench for dense_argmax.
// Margin checks run only when DENSE_ARGMAX_MARGIN_EN is defined.
module tb_dense_argmax;

    localparam int W    = 8;
    localparam int AW   = 8;
    localparam int MINV = -128;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 result_en = 1'b0;
    logic [3:0]           out_n = '0;
    logic [AW-1:0]        base = '0;
    logic signed [W-1:0]  qp;
    logic                 re_p;
    logic [AW-1:0]        read_addressp;
    logic [3:0]           class_o;
    logic signed [W-1:0]  max_o;
    logic                 STOP;
`ifdef DENSE_ARGMAX_MARGIN_EN
    logic signed [W:0]    margin_o;
`endif

    logic signed [W-1:0]  mem [0:255];
    logic [AW-1:0]        a_pipe = '0;

    int checks = 0;
    int errors = 0;
    int stop_edge, re_cnt, addr1;

    always #5 clk = ~clk;

    always @(posedge clk) a_pipe <= read_addressp;
    assign qp = mem[a_pipe];

    dense_argmax #(
        .SIZE_1           (W),
        .SIZE_address_pix (AW),
        .READ_LAT         (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .result_en     (result_en),
        .out           (out_n),
        .memstartp     (base),
        .qp            (qp),
        .re_p          (re_p),
        .read_addressp (read_addressp),
        .class_o       (class_o),
        .max_o         (max_o),
`ifdef DENSE_ARGMAX_MARGIN_EN
        .margin_o      (margin_o),
`endif
        .STOP          (STOP)
    );

    task automatic check(input string tag,
                         input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [3:0] n, input logic [AW-1:0] b,
                       input int lim);
        out_n = n;
        base = b;
        result_en = 1'b1;
        stop_edge = -1;
        re_cnt = 0;
        addr1 = -1;
        for (int i = 1; i <= lim; i++) begin
            step();
            if (i == 1) addr1 = int'(read_addressp);
            if (re_p) re_cnt++;
            if (STOP && stop_edge < 0) stop_edge = i;
        end
    endtask

    task automatic check_clear(input string tag);
        check({tag, "_re"}, re_p, 0);
        check({tag, "_stop"}, STOP, 0);
        check({tag, "_class"}, class_o, 0);
        check({tag, "_max"}, max_o, MINV);
        check({tag, "_addr"}, read_addressp, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;

        #12;
        check_clear("reset");
        rst_n = 1'b1;
        step();

        mem[16] = 3;  mem[17] = -5; mem[18] = 7;  mem[19] = 2;
        mem[20] = 7;  mem[21] = 0;  mem[22] = -1; mem[23] = 6;
        mem[24] = 1;  mem[25] = 4;
        run(4'd10, 8'd16, 16);
        check("t1_stop_edge", stop_edge, 12);
        check("t1_class", class_o, 2);
        check("t1_max", max_o, 7);
        check("t1_re_cycles", re_cnt, 10);
        check("t1_addr_e1", addr1, 16);
        check("t1_stop_held", STOP, 1);
        result_en = 1'b0;
        step();
        check_clear("t1_drop");

        for (int i = 40; i < 44; i++) mem[i] = -128;
        run(4'd4, 8'd40, 10);
        check("t2_stop_edge", stop_edge, 6);
        check("t2_class", class_o, 0);
        check("t2_max", max_o, MINV);
        check("t2_re_cycles", re_cnt, 4);
        result_en = 1'b0;
        step();

        run(4'd0, 8'd0, 4);
        check("t3_stop_edge", stop_edge, 1);
        check("t3_re_cycles", re_cnt, 0);
        check("t3_class", class_o, 0);
        check("t3_max", max_o, MINV);
`ifdef DENSE_ARGMAX_MARGIN_EN
        check("t3_margin", margin_o, 255);
`endif
        result_en = 1'b0;
        step();

        run(4'd10, 8'd16, 4);
        check("t4_partial_max", max_o, 3);
        result_en = 1'b0;
        step();
        check_clear("t4_abort");
        for (int i = 16; i < 25; i++) mem[i] = 0;
        mem[25] = 9;
        step();
        run(4'd10, 8'd16, 14);
        check("t4_stop_edge", stop_edge, 12);
        check("t4_class", class_o, 9);
        check("t4_max", max_o, 9);
        result_en = 1'b0;
        step();

        run(4'd10, 8'd16, 4);
        check("t5_re_before", re_p, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_clear("t5_async");
        result_en = 1'b0;
        rst_n = 1'b1;
        step();

`ifdef DENSE_ARGMAX_MARGIN_EN
        mem[60] = 5; mem[61] = 9; mem[62] = 9; mem[63] = 1;
        run(4'd4, 8'd60, 8);
        check("m1_class", class_o, 1);
        check("m1_margin", margin_o, 0);
        result_en = 1'b0;
        step();
        mem[62] = 2;
        run(4'd4, 8'd60, 8);
        check("m2_class", class_o, 1);
        check("m2_margin", margin_o, 4);
        result_en = 1'b0;
        step();
        check("m2_margin_clr", margin_o, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dense_argmax.md
Name: dense_argmax

Overview:
- Final stage of the neuroset inference pipeline, directly downstream of the dense layer.
- Once the last dense layer has written its `out` signed activations to pixel memory starting at `memstartp`, this block reads them back one per cycle and tracks the running maximum.
- It reports the winning class index and its value, then raises STOP.
- The top-level sequencer enables it with `result_en`, the same way it enables the dense layer.

Parameters:
- SIZE_1, 0, signed activation width; must match the dense layer's SIZE_1.
- SIZE_address_pix, 0, pixel-memory address width.
- READ_LAT, 1, memory read latency in cycles: data for an address driven after edge e is valid on qp at edge e+READ_LAT+1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- result_en  in  1  level enable; low forces IDLE and clears the block.
- out  in  4  number of classes to scan (0..15).
- memstartp  in  SIZE_address_pix  base address of the dense outputs.
- qp  in  SIZE_1 signed  memory read data.
- re_p  out  1  memory read enable.
- read_addressp  out  SIZE_address_pix  memory read address.
- class_o  out  4  index of the maximum element.
- max_o  out  SIZE_1 signed  value of the maximum element.
- STOP  out  1  result valid/done; held high while result_en stays high.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0, asynchronous) and result_en=0 (synchronous, applied at the next edge) both force: state=IDLE, re_p=0, read_addressp=0, class_o=0, max_o=-2^(SIZE_1-1), STOP=0, all internal counters=0.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE -> READ on the first edge with result_en=1 (call this edge 1):
  - that edge registers re_p=1 and read_addressp=memstartp;
  - the issue counter becomes 1.
- READ, each edge:
  - read_addressp = memstartp + issue count; issue count increments;
  - after the edge that issues address memstartp+out-1, re_p drops to 0 and the state moves to DRAIN.
- Sample pipeline:
  - a READ_LAT+1 deep shift register of valid bits tracks outstanding reads;
  - on each edge where a sample arrives, the sample counter k (0-based) is compared against the running max;
  - qp > max_o (signed, strict) -> max_o=qp, class_o=k;
  - ties keep the earlier index.
- Element 0 is always accepted, even when it equals the most negative value.
- DRAIN -> DONE on the edge that consumes sample out-1. That same edge updates class_o/max_o and sets STOP=1.
- STOP timing: STOP rises at edge out+READ_LAT+1.
- DONE: outputs are frozen and STOP is held while result_en=1. When result_en falls, the block returns to IDLE and clears everything. A fresh run requires result_en low for at least 1 cycle.
- out=0: IDLE -> DONE at edge 1 with no reads; STOP=1, class_o=0, max_o=-2^(SIZE_1-1).
- result_en dropping mid-scan: abort at the next edge and clear all outputs. Reads in flight are discarded because the valid shift register is cleared.
- Address arithmetic wraps modulo 2^SIZE_address_pix; no range check is performed.
- class_o never exceeds out-1.

Optional Feature:
- Macro: DENSE_ARGMAX_MARGIN_EN.
- Defined:
  - adds output margin_o (SIZE_1+1 bits, signed) = max_o minus the second-largest value;
  - a second running register (second_max) is updated whenever an element displaces the max or lies strictly between second_max and max;
  - on ties with the max, second_max takes the tied value, so margin_o=0;
  - margin_o is valid with STOP;
  - margin_o resets to 0;
  - when out<=1, margin_o = 2^SIZE_1 - 1 (saturated).
- Undefined: no port and no logic; behaviour is otherwise identical.

Decomposition:
- Shared package neuroset_pkg holds:
  - state enum (ARGMAX_IDLE/READ/DRAIN/DONE);
  - constant for the most negative SIZE_1 value;
  - class-index width (4).
- One sub-module, argmax_cmp: a registered compare-and-update cell (value, index, valid in; max, index out; optional second-max path). It is reused if the team later adds a top-k variant.

Test Plan:
- out=10, READ_LAT=1, memory [3,-5,7,2,7,0,-1,6,1,4] -> STOP at edge 12, class_o=2, max_o=7 (tie at index 4 ignored), re_p high exactly 10 cycles.
- out=4, all values -2^(SIZE_1-1) -> class_o=0, max_o=-2^(SIZE_1-1), STOP at edge 6.
- out=0 -> STOP at edge 1, no re_p pulse, class_o=0.
- out=10; drop result_en at edge 5, re-enable 2 cycles later with new data [0,0,0,0,0,0,0,0,0,9] -> first run aborted with outputs cleared; second run gives class_o=9, max_o=9.
- rst_n pulsed low asynchronously mid-READ -> all outputs reset immediately, without waiting for a clock edge.
- DENSE_ARGMAX_MARGIN_EN defined: [5,9,9,1] -> class_o=1, margin_o=0; [5,9,2,1] -> margin_o=4.
